// File: rtl/serial_master_port.sv
// Purpose: bus master port; arbitrates, serialises the header, then moves write/read beats bit-serially, LSB first.
// Latency: 1 ARB cycle minimum, H header cycles, then DATA_LEN cycles per write beat or DATA_LEN valid bits per read beat.
// Backpressure: one request at a time (req_ready only when idle); per-beat stall on slave_ready/wr_valid/slave_valid, aborted by timeout.
module serial_master_port #(
  parameter int SLAVE_LEN = 2,
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [SLAVE_LEN-1:0] req_slave,
  input  logic [ADDR_LEN-1:0]  req_addr,
  input  logic [BURST_LEN-1:0] req_burst,
  input  logic [DATA_LEN-1:0]  wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [DATA_LEN-1:0]  rd_data,
  output logic                 rd_valid,
  output logic                 done,
  output logic                 err,
  output logic                 approval_request,
  input  logic                 approval_grant,
  input  logic                 busy,
  output logic                 tx_slave_select,
  output logic                 tx_address,
  output logic                 tx_burst_number,
  output logic                 tx_data,
  output logic                 write_en,
  output logic                 read_en,
  output logic                 master_valid,
  output logic                 master_ready,
  input  logic                 slave_ready,
  input  logic                 slave_valid,
  input  logic                 rx_data
);

  // Header length is the widest of the three serial fields.
  localparam int HMAX = (SLAVE_LEN > ADDR_LEN) ? SLAVE_LEN : ADDR_LEN;
  localparam int H    = (HMAX > BURST_LEN) ? HMAX : BURST_LEN;
  localparam int HW   = $clog2(H + 1);
  localparam int DW   = $clog2(DATA_LEN + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_HDR, S_BEAT_WAIT, S_WSHIFT, S_RSHIFT, S_FIN, S_ABORT
  } state_t;

  state_t               state_q, state_d;
  logic                 write_q, write_d;
  logic [SLAVE_LEN-1:0] sel_sh_q, sel_sh_d;
  logic [ADDR_LEN-1:0]  addr_sh_q, addr_sh_d;
  logic [BURST_LEN-1:0] burst_sh_q, burst_sh_d;
  logic [BURST_LEN-1:0] beats_q, beats_d;
  logic [HW-1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [DW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_LEN-1:0]  data_sh_q, data_sh_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic [DATA_LEN-1:0]  rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;

  // State and datapath registers; reset returns everything to idle immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      sel_sh_q   <= '0;
      addr_sh_q  <= '0;
      burst_sh_q <= '0;
      beats_q    <= '0;
      hdr_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      data_sh_q  <= '0;
      to_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      sel_sh_q   <= sel_sh_d;
      addr_sh_q  <= addr_sh_d;
      burst_sh_q <= burst_sh_d;
      beats_q    <= beats_d;
      hdr_cnt_q  <= hdr_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_sh_q  <= data_sh_d;
      to_cnt_q   <= to_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state and output decode; grant loss overrides any progress in HDR..RSHIFT.
  always_comb begin
    logic [DATA_LEN-1:0] rx_shift;
    state_d    = state_q;
    write_d    = write_q;
    sel_sh_d   = sel_sh_q;
    addr_sh_d  = addr_sh_q;
    burst_sh_d = burst_sh_q;
    beats_d    = beats_q;
    hdr_cnt_d  = hdr_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_sh_d  = data_sh_q;
    to_cnt_d   = to_cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rx_shift   = data_sh_q >> 1;
    rx_shift[DATA_LEN-1] = rx_data;

    req_ready       = 1'b0;
    wr_ready        = 1'b0;
    done            = 1'b0;
    err             = 1'b0;
    master_valid    = 1'b0;
    master_ready    = 1'b0;
    tx_slave_select = 1'b0;
    tx_address      = 1'b0;
    tx_burst_number = 1'b0;
    tx_data         = 1'b0;
    approval_request = (state_q != S_IDLE);
    write_en = write_q && (state_q inside {S_HDR, S_BEAT_WAIT, S_WSHIFT, S_RSHIFT, S_FIN, S_ABORT});
    read_en  = !write_q && (state_q inside {S_HDR, S_BEAT_WAIT, S_WSHIFT, S_RSHIFT, S_FIN, S_ABORT});

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        to_cnt_d  = '0;
        hdr_cnt_d = '0;
        bit_cnt_d = '0;
        if (req_valid) begin
          write_d    = req_write;
          sel_sh_d   = req_slave;
          addr_sh_d  = req_addr;
          burst_sh_d = req_burst;
          // A zero burst count still moves one beat.
          beats_d    = (req_burst == '0) ? BURST_LEN'(1) : req_burst;
          state_d    = S_ARB;
        end
      end
      S_ARB: begin
        if (approval_grant && !busy) state_d = S_HDR;
      end
      S_HDR: begin
        master_valid    = 1'b1;
        tx_slave_select = sel_sh_q[0];
        tx_address      = addr_sh_q[0];
        tx_burst_number = burst_sh_q[0];
        // Shifting in zeros makes exhausted fields drive 0.
        sel_sh_d   = sel_sh_q >> 1;
        addr_sh_d  = addr_sh_q >> 1;
        burst_sh_d = burst_sh_q >> 1;
        hdr_cnt_d  = hdr_cnt_q + HW'(1);
        if (!approval_grant)                state_d = S_ABORT;
        else if (hdr_cnt_q == HW'(H - 1))   state_d = S_BEAT_WAIT;
      end
      S_BEAT_WAIT: begin
        if (write_q) begin
          wr_ready = slave_ready && approval_grant;
          if (!approval_grant) begin
            state_d = S_ABORT;
          end else if (wr_valid && slave_ready) begin
            data_sh_d = wr_data;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            state_d   = S_WSHIFT;
          end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
            state_d = S_ABORT;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end else begin
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = approval_grant ? S_RSHIFT : S_ABORT;
        end
      end
      S_WSHIFT: begin
        master_valid = 1'b1;
        tx_data      = data_sh_q[0];
        data_sh_d    = data_sh_q >> 1;
        bit_cnt_d    = bit_cnt_q + DW'(1);
        if (!approval_grant) begin
          state_d = S_ABORT;
        end else if (bit_cnt_q == DW'(DATA_LEN - 1)) begin
          bit_cnt_d = '0;
          beats_d   = beats_q - BURST_LEN'(1);
          state_d   = (beats_q == BURST_LEN'(1)) ? S_FIN : S_BEAT_WAIT;
        end
      end
      S_RSHIFT: begin
        master_ready = 1'b1;
        if (!approval_grant) begin
          state_d = S_ABORT;
        end else if (slave_valid) begin
          to_cnt_d  = '0;
          data_sh_d = rx_shift;
          bit_cnt_d = bit_cnt_q + DW'(1);
          if (bit_cnt_q == DW'(DATA_LEN - 1)) begin
            bit_cnt_d  = '0;
            rd_data_d  = rx_shift;
            rd_valid_d = 1'b1;
            beats_d    = beats_q - BURST_LEN'(1);
            state_d    = (beats_q == BURST_LEN'(1)) ? S_FIN : S_RSHIFT;
          end
        end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/serial_master_port.md
Name: serial_master_port

Overview:
Parametrised next-generation bus master port. Accepts one read or write burst request from the local master core, arbitrates for the shared bus, and serialises the header: slave select, address and burst count, each on its own 1-bit line. It then serialises write beats or deserialises read beats, LSB first. Adds a request/ready host handshake, multi-beat bursts with per-beat flow control, a slave-response timeout, and abort on grant loss.

Parameters:
SLAVE_LEN, 2, width of slave select field
ADDR_LEN, 12, width of address field
DATA_LEN, 8, width of one data beat
BURST_LEN, 12, width of burst count field (beats = value; value 0 is treated as 1)
TIMEOUT, 255, max consecutive cycles waiting on slave_ready/slave_valid before abort (counter width = clog2(TIMEOUT+1))

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  host request present
req_ready  out  1  port idle, request accepted when req_valid&&req_ready
req_write  in  1  1=write, 0=read
req_slave  in  SLAVE_LEN  target slave
req_addr  in  ADDR_LEN  start address
req_burst  in  BURST_LEN  beat count
wr_data  in  DATA_LEN  write beat
wr_valid  in  1  write beat available
wr_ready  out  1  write beat accepted this cycle
rd_data  out  DATA_LEN  received read beat
rd_valid  out  1  one-cycle pulse, rd_data valid
done  out  1  one-cycle pulse, burst completed normally
err  out  1  one-cycle pulse, burst aborted
approval_request  out  1  bus request to arbiter
approval_grant  in  1  arbiter grant
busy  in  1  bus held by another master
tx_slave_select  out  1  serial slave select
tx_address  out  1  serial address
tx_burst_number  out  1  serial burst count
tx_data  out  1  serial write data
write_en  out  1  write transaction in progress
read_en  out  1  read transaction in progress
master_valid  out  1  header/write bit valid on tx lines
master_ready  out  1  master ready to sample rx_data
slave_ready  in  1  slave ready for next write beat / header
slave_valid  in  1  rx_data bit valid
rx_data  in  1  serial read data

Behaviour:
- Reset (reset=0, async): state IDLE; req_ready=1; all other outputs 0; shift registers, beat and timeout counters cleared.
- Request fields latched on acceptance. req_ready=1 only in IDLE.
- States: IDLE, ARB, HDR, BEAT_WAIT, WSHIFT, RSHIFT, FIN, ABORT.
- IDLE -> ARB on accept. ARB: approval_request=1.
- ARB -> HDR when approval_grant=1 && busy=0. A grant arriving while busy=1 is ignored.
- approval_request stays 1 from ARB through FIN/ABORT. It drops the cycle the FSM returns to IDLE.
- HDR: H = max(SLAVE_LEN, ADDR_LEN, BURST_LEN) cycles, master_valid=1.
- During HDR, bit i of each field drives its line on cycle i, LSB first. A line whose field is exhausted drives 0.
- write_en or read_en is asserted from HDR entry until IDLE.
- HDR -> BEAT_WAIT.
- BEAT_WAIT, write: wr_ready=1 when slave_ready=1. On wr_valid&&wr_ready, load wr_data and go to WSHIFT.
- BEAT_WAIT, read: go directly to RSHIFT.
- WSHIFT: DATA_LEN cycles, tx_data=bit k, master_valid=1. After the last bit, decrement the beat counter, then go to BEAT_WAIT, or to FIN if the counter reaches 0.
- RSHIFT: master_ready=1. Each cycle with slave_valid=1 shifts in rx_data LSB first. Cycles with slave_valid=0 stall.
- RSHIFT beat completion: after DATA_LEN valid bits, rd_data is updated and rd_valid pulses the next cycle. The beat counter decrements; the FSM re-enters RSHIFT, or goes to FIN if the counter reaches 0.
- Timeout counter clears on any progress: a beat accepted or a valid bit received. It increments each stalled cycle in BEAT_WAIT/RSHIFT. Reaching TIMEOUT -> ABORT.
- Stall for write means slave_ready=0 or wr_valid=0.
- approval_grant falling in any state HDR..WSHIFT/RSHIFT -> ABORT next cycle. A partial beat is discarded: no rd_valid.
- FIN: done=1 for one cycle -> IDLE. ABORT: err=1 for one cycle, all tx lines 0 -> IDLE.
- done and err are never asserted together.
- req_burst=0 executes exactly one beat.
- Reset mid-burst returns immediately to reset values. No done/err pulse is produced.

Test Plan:
- Write, slave=2, addr=0xA5C, burst=1, data=0x3C, grant after 3 cycles, busy=0 -> HDR 12 cycles: tx_address bits 0,0,1,1,1,0,1,0,0,1,0,1; tx_data 0,0,1,1,1,1,0,0; done pulse; err=0.
- Read, burst=3, slave streams 0x11,0x22,0x33 with a 2-cycle slave_valid gap mid-beat 2 -> rd_valid pulses 3 times with rd_data 0x11,0x22,0x33; done once.
- Grant asserted while busy=1 for 5 cycles -> stays in ARB, tx lines 0; HDR starts the cycle after busy falls.
- Write, burst=2, slave_ready held 0 after beat 1 for 255 cycles -> err pulse at timeout, done never, approval_request drops, req_ready=1 next cycle.
- Read, approval_grant dropped at bit 4 of beat 1 -> err next cycle, no rd_valid, return to IDLE.
- Assert reset low mid-WSHIFT -> all outputs 0 asynchronously, req_ready=1; a fresh request after release completes normally.
